aes_encipher_block: RTL and testbench

Iterative AES-128 encryption datapath: the forward counterpart of the AES decipher block, driven by the same round-key provider and the same next/ready handshake. It takes one 128-bit plaintext block and applies AddRoundKey, SubBytes, ShiftRows and MixColumns over NR rounds. SubBytes is done one 32-bit word per cycle through a single shared forward S-box. It sits in the AES core next to the decipher block; the core muxes round_o, new_block_o and ready_o on the encdec select.

---
 rtl/aes_pkg.sv | 58 +++++
 rtl/aes_encipher_block_if.sv | 22 ++
 rtl/aes_sbox.sv | 33 +++
 rtl/aes_encipher_block.sv | 130 +++++++++++++
 tb/tb_aes_encipher_block.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, constants and cipher round functions
package aes_pkg;

  localparam int unsigned AES_ROUND = 10;
  localparam int unsigned KEY_WIDTH = 128;

  typedef enum logic [1:0] {
    CTRL_IDLE = 2'd0,
    CTRL_INIT = 2'd1,
    CTRL_SBOX = 2'd2,
    CTRL_MAIN = 2'd3
  } ctrl_state_e;

  typedef enum logic [2:0] {
    UPD_NO    = 3'd0,
    UPD_INIT  = 3'd1,
    UPD_SBOX  = 3'd2,
    UPD_MAIN  = 3'd3,
    UPD_FINAL = 3'd4
  } update_e;

  // Multiply by x in GF(2^8), reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column through the {02,03,01,01} circulant matrix.
  function automatic logic [31:0] mixw(input logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] m0, m1, m2, m3;
    b0 = w[31:24];
    b1 = w[23:16];
    b2 = w[15:8];
    b3 = w[7:0];
    m0 = xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3;
    m1 = b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3;
    m2 = b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3;
    m3 = xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3);
    return {m0, m1, m2, m3};
  endfunction

  function automatic logic [127:0] mixcolumns(input logic [127:0] b);
    return {mixw(b[127:96]), mixw(b[95:64]), mixw(b[63:32]), mixw(b[31:0])};
  endfunction

  // Byte 4*col+row (MSB-first); row r rotates left by r columns.
  function automatic logic [127:0] shiftrows(input logic [127:0] b);
    logic [127:0] r;
    r = '0;
    for (int col = 0; col < 4; col++) begin
      for (int row = 0; row < 4; row++) begin
        r[127 - 8*(4*col + row) -: 8] = b[127 - 8*(4*((col + row) % 4) + row) -: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_encipher_block_if.sv
// rtl/aes_encipher_block_if.sv - round-key / block / next-ready bundle of the encipher block
interface aes_encipher_block_if;
  import aes_pkg::*;

  logic                 next;
  logic [3:0]           round;
  logic [KEY_WIDTH-1:0] round_key;
  logic [127:0]         block;
  logic [127:0]         new_block;
  logic                 ready;

  modport master (
    output next, round_key, block,
    input  round, new_block, ready
  );

  modport slave (
    input  next, round_key, block,
    output round, new_block, ready
  );

endinterface

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - 32-bit forward AES S-box, four parallel byte lookups
module aes_sbox (
  input  logic [31:0] sword,
  output logic [31:0] new_sword
);

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] lookup(input logic [7:0] x);
    return SBOX_TABLE[2047 - 8*int'(x) -: 8];
  endfunction

  assign new_sword = {lookup(sword[31:24]), lookup(sword[23:16]),
                      lookup(sword[15:8]),  lookup(sword[7:0])};

endmodule

// File: rtl/aes_encipher_block.sv
// rtl/aes_encipher_block.sv - iterative AES-128 encryption datapath, one S-box word per cycle
module aes_encipher_block #(
  parameter int unsigned NR        = aes_pkg::AES_ROUND,
  parameter int unsigned KEY_WIDTH = aes_pkg::KEY_WIDTH
) (
  input  logic                clk_i,
  input  logic                rst_i,
  aes_encipher_block_if.slave bus
);
  import aes_pkg::*;

  ctrl_state_e          state_q, state_d;
  update_e              upd;
  logic [31:0]          w0_q, w1_q, w2_q, w3_q;
  logic [1:0]           sword_q, sword_d;
  logic [3:0]           round_q, round_d;
  logic                 ready_q, ready_d;
  logic [127:0]         block_q, block_d;
  logic [31:0]          sbox_in, sbox_out;
  logic [KEY_WIDTH-1:0] round_key;

  assign round_key     = bus.round_key;
  assign block_q       = {w0_q, w1_q, w2_q, w3_q};
  assign bus.round     = round_q;
  assign bus.new_block = block_q;
  assign bus.ready     = ready_q;

  aes_sbox u_sbox (
    .sword     (sbox_in),
    .new_sword (sbox_out)
  );

  // Pick the word being substituted this cycle.
  always_comb begin
    sbox_in = w0_q;
    case (sword_q)
      2'd0:    sbox_in = w0_q;
      2'd1:    sbox_in = w1_q;
      2'd2:    sbox_in = w2_q;
      default: sbox_in = w3_q;
    endcase
  end

  // Control FSM: next state, counters, ready and the kind of block update.
  always_comb begin
    state_d = state_q;
    upd     = UPD_NO;
    round_d = round_q;
    sword_d = sword_q;
    ready_d = ready_q;
    case (state_q)
      CTRL_IDLE: begin
        if (bus.next) begin
          round_d = 4'd0;
          ready_d = 1'b0;
          state_d = CTRL_INIT;
        end
      end
      CTRL_INIT: begin
        upd     = UPD_INIT;
        round_d = 4'd1;
        sword_d = 2'd0;
        state_d = CTRL_SBOX;
      end
      CTRL_SBOX: begin
        upd     = UPD_SBOX;
        sword_d = sword_q + 2'd1;
        if (sword_q == 2'd3) begin
          state_d = CTRL_MAIN;
        end
      end
      CTRL_MAIN: begin
        sword_d = 2'd0;
        if (round_q < 4'(NR)) begin
          upd     = UPD_MAIN;
          round_d = round_q + 4'd1;
          state_d = CTRL_SBOX;
        end else begin
          upd     = UPD_FINAL;
          ready_d = 1'b1;
          state_d = CTRL_IDLE;
        end
      end
      default: state_d = CTRL_IDLE;
    endcase
  end

  // Block update selected by the FSM; only the addressed word changes in SBOX.
  always_comb begin
    block_d = block_q;
    case (upd)
      UPD_INIT:  block_d = bus.block ^ round_key;
      UPD_SBOX: begin
        case (sword_q)
          2'd0:    block_d[127:96] = sbox_out;
          2'd1:    block_d[95:64]  = sbox_out;
          2'd2:    block_d[63:32]  = sbox_out;
          default: block_d[31:0]   = sbox_out;
        endcase
      end
      UPD_MAIN:  block_d = mixcolumns(shiftrows(block_q)) ^ round_key;
      UPD_FINAL: block_d = shiftrows(block_q) ^ round_key;
      default:   block_d = block_q;
    endcase
  end

  // State, counter and block registers; reset discards any operation in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CTRL_IDLE;
      sword_q <= 2'd0;
      round_q <= 4'd0;
      ready_q <= 1'b1;
      w0_q    <= 32'd0;
      w1_q    <= 32'd0;
      w2_q    <= 32'd0;
      w3_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      sword_q <= sword_d;
      round_q <= round_d;
      ready_q <= ready_d;
      w0_q    <= block_d[127:96];
      w1_q    <= block_d[95:64];
      w2_q    <= block_d[63:32];
      w3_q    <= block_d[31:0];
    end
  end

endmodule

// File: tb/tb_aes_encipher_block.sv
// tb/tb_aes_encipher_block.sv - directed FIPS-197 vector bench for aes_encipher_block
module tb_aes_encipher_block;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst;
  logic key_sel;
  logic [127:0] rk_b [16];
  logic [127:0] rk_c [16];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_encipher_block_if ifc ();

  aes_encipher_block #(.NR(10), .KEY_WIDTH(128)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc.slave)
  );

  assign ifc.round_key = key_sel ? rk_c[ifc.round] : rk_b[ifc.round];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = m_xtime(x);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [7:0] inv, s;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  task automatic expand(input logic [127:0] key, input logic sel);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {m_sbox(t[31:24]), m_sbox(t[23:16]), m_sbox(t[15:8]), m_sbox(t[7:0])};
        t = t ^ {rcon, 24'h0};
        rcon = m_xtime(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      logic [127:0] k;
      k = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
      if (sel) rk_c[r] = k;
      else     rk_b[r] = k;
    end
  endtask

  // Pulse (or hold) next and count edges until ready is seen high again.
  task automatic run(input logic hold, output int lat);
    ifc.next = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!hold) ifc.next = 1'b0;
    end while (!ifc.ready && lat < 200);
  endtask

  initial begin
    int lat;
    int gap;
    int round_bad;
    int exp_round;
    rst       = 1'b1;
    ifc.next  = 1'b0;
    ifc.block = '0;
    key_sel   = 1'b0;
    expand(KEY_B, 1'b0);
    expand(KEY_C, 1'b1);
    repeat (3) @(negedge clk);
    check("reset_ready", 128'(ifc.ready), 128'd1);
    check("reset_block", ifc.new_block, 128'h0);
    check("reset_round", 128'(ifc.round), 128'd0);
    rst = 1'b0;
    @(negedge clk);

    // App. B
    ifc.block = PT_B;
    run(1'b0, lat);
    check("appb_latency", 128'(lat), 128'd52);
    check("appb_ct", ifc.new_block, CT_B);

    // App. C.1 with round_o trace
    key_sel   = 1'b1;
    ifc.block = PT_C;
    ifc.next  = 1'b1;
    lat       = 0;
    round_bad = 0;
    do begin
      @(negedge clk);
      ifc.next = 1'b0;
      lat++;
      if (!ifc.ready) begin
        exp_round = (lat == 1) ? 0 : (lat - 2) / 5 + 1;
        if (int'(ifc.round) != exp_round) round_bad++;
        if (lat == 1)  check("appc_round_init", 128'(ifc.round), 128'd0);
        if (lat == 51) check("appc_round_last", 128'(ifc.round), 128'd10);
      end
    end while (!ifc.ready && lat < 200);
    check("appc_round_seq", 128'(round_bad), 128'd0);
    check("appc_latency", 128'(lat), 128'd52);
    check("appc_ct", ifc.new_block, CT_C);

    // next held high through the whole operation
    run(1'b1, lat);
    check("hold_latency", 128'(lat), 128'd52);
    check("hold_ct", ifc.new_block, CT_C);
    @(negedge clk);
    check("hold_restart_ready", 128'(ifc.ready), 128'd0);
    check("hold_restart_round", 128'(ifc.round), 128'd0);
    ifc.next = 1'b0;
    lat = 1;
    while (!ifc.ready && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("hold_second_latency", 128'(lat), 128'd52);
    check("hold_second_ct", ifc.new_block, CT_C);

    // reset in the middle of an encryption
    key_sel   = 1'b0;
    ifc.block = PT_B;
    ifc.next  = 1'b1;
    @(negedge clk);
    ifc.next = 1'b0;
    repeat (19) @(negedge clk);
    check("midrun_busy", 128'(ifc.ready), 128'd0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", 128'(ifc.ready), 128'd1);
    check("midrst_block", ifc.new_block, 128'h0);
    check("midrst_round", 128'(ifc.round), 128'd0);
    rst = 1'b0;
    @(negedge clk);
    run(1'b0, lat);
    check("postrst_latency", 128'(lat), 128'd52);
    check("postrst_ct", ifc.new_block, CT_B);

    // back-to-back App. B then App. C.1
    run(1'b0, lat);
    check("b2b_first_ct", ifc.new_block, CT_B);
    gap = 0;
    @(negedge clk);
    gap++;
    ifc.block = PT_C;
    key_sel   = 1'b1;
    ifc.next  = 1'b1;
    @(negedge clk);
    gap++;
    ifc.next = 1'b0;
    while (!ifc.ready && gap < 200) begin
      @(negedge clk);
      gap++;
    end
    check("b2b_gap", 128'(gap), 128'd53);
    check("b2b_second_ct", ifc.new_block, CT_C);
    repeat (5) @(negedge clk);
    check("idle_hold_ct", ifc.new_block, CT_C);
    check("idle_hold_ready", 128'(ifc.ready), 128'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
